// File: rtl/sdram_rr_arbiter.sv
// Two-requester round-robin Avalon-MM arbiter in front of the SDRAM controller.
// One command in flight at a time; read responses are routed back by a small ID FIFO.
module sdram_rr_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_PEND = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*AW-1:0]     req_address,
  input  logic [1:0]          req_read,
  input  logic [1:0]          req_write,
  input  logic [2*DW-1:0]     req_writedata,
  input  logic [2*DW/8-1:0]   req_byteenable,
  output logic [1:0]          req_waitrequest,
  output logic [DW-1:0]       req_readdata,
  output logic [1:0]          req_readdatavalid,
  output logic [AW-1:0]       m_address,
  output logic                m_read,
  output logic                m_write,
  output logic [DW-1:0]       m_writedata,
  output logic [DW/8-1:0]     m_byteenable,
  input  logic                m_waitrequest,
  input  logic [DW-1:0]       m_readdata,
  input  logic                m_readdatavalid,
  output logic                err
);

  localparam int BW = DW / 8;
  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_PEND - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_reg, state_next;
  logic           sel_reg, sel_next;
  logic           last_reg, last_next;
  logic           err_reg, err_next;
  logic [CW-1:0]  pend_reg, pend_next;
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic           fifo_mem [MAX_PEND];

  logic [1:0]     both_strobes;
  logic [1:0]     eligible;
  logic           fifo_empty, pop, push, accepted, read_room, busy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign busy       = (state_reg == BUSY);
  assign fifo_empty = (pend_reg == '0);
  assign pop        = m_readdatavalid && !fifo_empty;
  // A slot freed by this cycle's pop counts, so a blocked read is granted on the pop cycle.
  assign read_room  = (pend_reg < PEND_MAX) || pop;

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign both_strobes[gi]      = req_read[gi] & req_write[gi];
    assign eligible[gi]          = (req_read[gi] ^ req_write[gi]) & (req_write[gi] | read_room);
    assign req_waitrequest[gi]   = !(busy && (sel_reg == 1'(gi))) || m_waitrequest;
    assign req_readdatavalid[gi] = pop && (fifo_mem[rd_ptr_reg] == 1'(gi));
  end

  assign m_address    = sel_reg ? req_address[2*AW-1:AW]    : req_address[AW-1:0];
  assign m_writedata  = sel_reg ? req_writedata[2*DW-1:DW]  : req_writedata[DW-1:0];
  assign m_byteenable = sel_reg ? req_byteenable[2*BW-1:BW] : req_byteenable[BW-1:0];
  assign m_read       = busy && req_read[sel_reg];
  assign m_write      = busy && req_write[sel_reg];
  assign req_readdata = m_readdata;
  assign err          = err_reg;

  assign accepted = (m_read || m_write) && !m_waitrequest;
  assign push     = accepted && m_read;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    err_next   = err_reg || (|both_strobes) || (m_readdatavalid && fifo_empty);
    unique case (state_reg)
      IDLE: begin
        if (|eligible) begin
          sel_next   = (&eligible) ? ~last_reg : eligible[1];
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (accepted) begin
          last_next  = sel_reg;
          state_next = IDLE;
        end else if (!req_read[sel_reg] && !req_write[sel_reg]) begin
          // Master withdrew its command while stalled.
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pend_next = pend_reg;
    unique case ({push, pop})
      2'b10:   pend_next = pend_reg + 1'b1;
      2'b01:   pend_next = pend_reg - 1'b1;
      default: pend_next = pend_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sel_reg    <= 1'b0;
      last_reg   <= 1'b1;
      err_reg    <= 1'b0;
      pend_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      err_reg   <= err_next;
      pend_reg  <= pend_next;
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

  // Entry contents need no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= sel_reg;
  end

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Directed bench for sdram_rr_arbiter: expected commands/responses are queued by the
// stimulus and consumed by a negedge monitor whenever the DUT presents one.
module tb_sdram_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] req_address;
  logic [1:0]  req_read, req_write;
  logic [63:0] req_writedata;
  logic [7:0]  req_byteenable;
  logic [1:0]  req_waitrequest;
  logic [31:0] req_readdata;
  logic [1:0]  req_readdatavalid;
  logic [31:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        err;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    bit          id;
    logic [31:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   failures = 0;

  sdram_rr_arbiter #(.AW(32), .DW(32), .MAX_PEND(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_address(req_address), .req_read(req_read), .req_write(req_write),
    .req_writedata(req_writedata), .req_byteenable(req_byteenable),
    .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Avalon master: present a command and hold it until waitrequest drops.
  task automatic issue(input int i, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    req_address[i*32 +: 32]  = addr;
    req_writedata[i*32 +: 32] = data;
    req_byteenable[i*4 +: 4] = be;
    req_read[i]  = !wr;
    req_write[i] = wr;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!req_waitrequest[i]) begin
        @(posedge clk);
        #1;
        req_read[i]  = 1'b0;
        req_write[i] = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout r%0d addr=0x%0h: got no acceptance, expected one within 50 cycles", i, addr);
    req_read[i]  = 1'b0;
    req_write[i] = 1'b0;
  endtask

  function automatic cmd_t mk_cmd(input bit wr, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] be);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.data = data; c.be = be;
    return c;
  endfunction

  function automatic rsp_t mk_rsp(input bit id, input logic [31:0] data);
    rsp_t r;
    r.id = id; r.data = data;
    return r;
  endfunction

  task automatic respond(input bit id, input logic [31:0] data);
    rsp_q.push_back(mk_rsp(id, data));
    m_readdatavalid = 1'b1;
    m_readdata      = data;
  endtask

  // Monitor: compares every accepted command and every routed response.
  always @(negedge clk) begin
    cmd_t e;
    rsp_t r;
    if (rst_n) begin
      if ((m_read || m_write) && !m_waitrequest) begin
        if (cmd_q.size() == 0) begin
          chk("unexpected_cmd", {m_read, m_write}, 2'b00);
        end else begin
          e = cmd_q.pop_front();
          $display("cmd %s addr=0x%0h data=0x%0h be=0x%0h", m_write ? "WR" : "RD",
                   m_address, m_writedata, m_byteenable);
          chk("cmd_kind", {m_read, m_write}, e.wr ? 2'b01 : 2'b10);
          chk("cmd_addr", m_address, e.addr);
          if (e.wr) begin
            chk("cmd_wdata", m_writedata, e.data);
            chk("cmd_be", m_byteenable, e.be);
          end
        end
      end
      if (req_readdatavalid != 2'b00) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", req_readdatavalid, 2'b00);
        end else begin
          r = rsp_q.pop_front();
          $display("rsp valid=%b data=0x%0h", req_readdatavalid, req_readdata);
          chk("rsp_route", req_readdatavalid, 2'b01 << r.id);
          chk("rsp_data", req_readdata, r.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected one before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_address = '0; req_read = '0; req_write = '0;
    req_writedata = '0; req_byteenable = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_m_read", m_read, 0);
    chk("rst_m_write", m_write, 0);
    chk("rst_waitreq", req_waitrequest, 2'b11);
    chk("rst_rdvalid", req_readdatavalid, 2'b00);
    chk("rst_err", err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single read, data returned 3 cycles after acceptance
    cmd_q.push_back(mk_cmd(1'b0, 32'h100, 32'h0, 4'h0));
    fork issue(0, 1'b0, 32'h100, 32'h0, 4'h0); join_none
    @(negedge clk); chk("single_idle_m_read", m_read, 0);
    @(negedge clk); chk("single_busy_m_read", m_read, 1);
    chk("single_busy_waitreq", req_waitrequest, 2'b10);
    @(negedge clk); chk("single_one_cycle_m_read", m_read, 0);
    tick();
    tick();
    respond(1'b0, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_rdvalid", req_readdatavalid, 2'b01);
    chk("single_rdata", req_readdata, 32'hDEADBEEF);
    tick();
    m_readdatavalid = 1'b0;

    // Reset pulse so the round-robin run starts from a fresh tie-break
    rst_n = 1'b0;
    #1 chk("pulse_waitreq", req_waitrequest, 2'b11);
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin: both requesters hold two reads each
    cmd_q.push_back(mk_cmd(1'b0, 32'h200, 32'h0, 4'h0));
    cmd_q.push_back(mk_cmd(1'b0, 32'h300, 32'h0, 4'h0));
    cmd_q.push_back(mk_cmd(1'b0, 32'h204, 32'h0, 4'h0));
    cmd_q.push_back(mk_cmd(1'b0, 32'h304, 32'h0, 4'h0));
    fork
      begin
        issue(0, 1'b0, 32'h200, 32'h0, 4'h0);
        issue(0, 1'b0, 32'h204, 32'h0, 4'h0);
      end
      begin
        issue(1, 1'b0, 32'h300, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h304, 32'h0, 4'h0);
      end
    join

    // Backpressure: four reads outstanding, a fifth must wait for a pop
    cmd_q.push_back(mk_cmd(1'b0, 32'h500, 32'h0, 4'h0));
    fork issue(0, 1'b0, 32'h500, 32'h0, 4'h0); join_none
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_waitreq", req_waitrequest, 2'b11);
      chk("full_m_read", m_read, 0);
    end
    tick();
    respond(1'b0, 32'hA000_0000);
    @(negedge clk); chk("pop_cycle_m_read", m_read, 0);
    tick();
    respond(1'b1, 32'hA000_0001);
    @(negedge clk);
    chk("after_pop_m_read", m_read, 1);
    chk("after_pop_addr", m_address, 32'h500);
    chk("after_pop_waitreq", req_waitrequest, 2'b10);
    tick(); respond(1'b0, 32'hA000_0002);
    tick(); respond(1'b1, 32'hA000_0003);
    tick(); respond(1'b0, 32'hA000_0004);
    tick();
    m_readdatavalid = 1'b0;
    tick();

    // Write under a 3-cycle controller stall
    m_waitrequest = 1'b1;
    cmd_q.push_back(mk_cmd(1'b1, 32'h40, 32'h55AA, 4'b0011));
    fork issue(1, 1'b1, 32'h40, 32'h55AA, 4'b0011); join_none
    @(negedge clk); chk("wr_idle_m_write", m_write, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wr_stall_m_write", m_write, 1);
      chk("wr_stall_addr", m_address, 32'h40);
      chk("wr_stall_wdata", m_writedata, 32'h55AA);
      chk("wr_stall_be", m_byteenable, 4'b0011);
      chk("wr_stall_waitreq", req_waitrequest, 2'b11);
    end
    tick();
    m_waitrequest = 1'b0;
    @(negedge clk);
    chk("wr_final_m_write", m_write, 1);
    chk("wr_final_addr", m_address, 32'h40);
    chk("wr_final_waitreq", req_waitrequest, 2'b01);
    tick();
    tick();

    // Read and write together on r0: never granted, err sticky
    chk("err_clear_before", err, 0);
    req_read[0] = 1'b1;
    req_write[0] = 1'b1;
    @(negedge clk);
    chk("rw_no_cmd", {m_read, m_write}, 2'b00);
    chk("rw_waitreq", req_waitrequest, 2'b11);
    @(negedge clk);
    chk("rw_no_cmd2", {m_read, m_write}, 2'b00);
    chk("rw_err", err, 1);
    tick();
    req_read[0] = 1'b0;
    req_write[0] = 1'b0;
    repeat (3) tick();
    chk("rw_err_sticky", err, 1);

    // Two reads outstanding, then an asynchronous reset mid-cycle
    cmd_q.push_back(mk_cmd(1'b0, 32'h600, 32'h0, 4'h0));
    cmd_q.push_back(mk_cmd(1'b0, 32'h700, 32'h0, 4'h0));
    fork
      issue(0, 1'b0, 32'h600, 32'h0, 4'h0);
      issue(1, 1'b0, 32'h700, 32'h0, 4'h0);
    join
    tick();
    #2;
    rst_n = 1'b0;
    m_readdatavalid = 1'b1;
    m_readdata = 32'h1234_5678;
    #1;
    chk("midrst_err", err, 0);
    chk("midrst_waitreq", req_waitrequest, 2'b11);
    chk("midrst_cmd", {m_read, m_write}, 2'b00);
    chk("midrst_rdvalid", req_readdatavalid, 2'b00);
    tick();
    rst_n = 1'b1;
    m_readdatavalid = 1'b0;
    tick();

    // Response with an empty FIFO after reset: dropped, err set
    chk("post_rst_err", err, 0);
    m_readdatavalid = 1'b1;
    m_readdata = 32'hBAD0_BAD0;
    @(negedge clk); chk("empty_rdvalid", req_readdatavalid, 2'b00);
    tick();
    m_readdatavalid = 1'b0;
    @(negedge clk); chk("empty_err", err, 1);
    tick();

    chk("cmd_queue_drained", cmd_q.size(), 0);
    chk("rsp_queue_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
